// File: rtl/data_mem_dump.sv
// Purpose: post-run dump engine; holds the CPU, reads a contiguous data-memory
//   word range and streams it out with address, last flag and running checksum.
// Ports: clk/reset; start, start_addr, word_count (dump request);
//   mem_addr/mem_rd_en/mem_rdata (sync read port, 1-cycle latency);
//   out_valid/out_ready/out_data/out_addr/out_last (stream);
//   cpu_hold, busy, done, checksum (status).
// Latency: 3 cycles per word (REQ, CAP, SEND), +1 cycle of done.
// Backpressure: each out_ready=0 cycle in SEND holds all outputs one more cycle.
module data_mem_dump #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_SEND,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH:0]   remaining;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (word_count == '0) ? S_DONE : S_REQ;
      S_REQ:  state_nxt = S_CAP;
      S_CAP:  state_nxt = S_SEND;
      S_SEND: if (out_ready) state_nxt = out_last ? S_DONE : S_REQ;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      checksum  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        addr_cnt  <= start_addr;
        remaining <= word_count;
        checksum  <= '0;
        out_last  <= 1'b0;
      end
      // Read data arrives one cycle after REQ; capture it so the stream
      // outputs are registered and independent of mem_rdata afterwards.
      if (state == S_CAP) begin
        out_data <= mem_rdata;
        out_addr <= addr_cnt;
        out_last <= (remaining == (ADDR_WIDTH+1)'(1));
      end
      // Counters advance only on an accepted word; the address wraps
      // naturally at the top of memory.
      if (state == S_SEND && out_ready) begin
        checksum  <= checksum + 32'(out_data);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
        addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  assign mem_addr  = addr_cnt;
  assign mem_rd_en = (state == S_REQ);
  assign out_valid = (state == S_SEND);
  assign busy      = (state == S_REQ) || (state == S_CAP) || (state == S_SEND);
  assign cpu_hold  = busy;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_data_mem_dump.sv
module tb_data_mem_dump;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic [31:0]   checksum;

  data_mem_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Data memory with a synchronous read port.
  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: on an accepted start the whole expected word list is built up front;
  // words leave the list on handshakes, done is due the cycle after the last one.
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          l;
  } item_t;

  item_t       q[$];
  item_t       it;
  bit          active = 0;
  bit          done_due = 0;
  bit          was_active;
  logic [31:0] msum = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_d;
  logic [AW-1:0] prev_a;
  logic        prev_l;
  int          cyc = 0, acc_cyc = 0, first_v_cyc = -1;
  int          n_busy = 0, n_done = 0, n_hs = 0;
  logic [31:0] hs_data[$];
  logic [AW-1:0] hs_addr[$];

  always @(negedge clk) begin
    cyc++;
    was_active = active;
    chk("busy", busy, active && !done_due);
    chk("cpu_hold", cpu_hold, active && !done_due);
    chk("done", done, done_due);
    chk("checksum", checksum, msum);
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_d);
      chk("stall_addr", out_addr, prev_a);
      chk("stall_last", out_last, prev_l);
    end
    if (mem_rd_en) begin
      if (q.size() == 0) chk("rd_unexpected", mem_rd_en, 0);
      else               chk("rd_addr", mem_addr, q[0].a);
    end
    if (out_valid) begin
      if (first_v_cyc < 0) first_v_cyc = cyc;
      if (q.size() == 0) chk("valid_unexpected", out_valid, 0);
      else begin
        chk("out_data", out_data, q[0].d);
        chk("out_addr", out_addr, q[0].a);
        chk("out_last", out_last, q[0].l);
      end
    end

    if (busy) n_busy++;
    if (done) n_done++;
    if (done_due) begin
      active   = 0;
      done_due = 0;
    end
    prev_stall = out_valid && !out_ready;
    prev_d = out_data;
    prev_a = out_addr;
    prev_l = out_last;
    if (out_valid && out_ready && q.size() > 0) begin
      it = q.pop_front();
      msum += it.d;
      n_hs++;
      hs_data.push_back(it.d);
      hs_addr.push_back(it.a);
      if (it.l) done_due = 1;
    end
    if (!was_active && start && !reset) begin
      active  = 1;
      acc_cyc = cyc;
      msum    = 0;
      for (int i = 0; i < int'(word_count); i++) begin
        it.a = AW'((int'(start_addr) + i) % 1024);
        it.d = mem[it.a];
        it.l = (i == int'(word_count) - 1);
        q.push_back(it);
      end
      if (word_count == 0) done_due = 1;
    end
    if (reset) begin
      active = 0;
      done_due = 0;
      q.delete();
      msum = 0;
      prev_stall = 0;
    end
  end

  task automatic reset_stats();
    n_busy = 0; n_done = 0; n_hs = 0; first_v_cyc = -1;
    hs_data.delete();
    hs_addr.delete();
  endtask

  task automatic start_dump(input int sa, input int wc);
    @(posedge clk); #1;
    start = 1; start_addr = AW'(sa); word_count = (AW+1)'(wc);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_until_done(input bit toggle, input bit restart, input int budget);
    bit did = 0;
    for (int i = 0; i < budget; i++) begin
      if (n_done > 0) break;
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      if (restart && out_valid && !did) begin
        start = 1; did = 1;
      end else start = 0;
    end
    start = 0;
    chk("done_within_budget", n_done > 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int nreq;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
    mem[4] = 32'h11; mem[5] = 32'h22; mem[6] = 32'h33; mem[7] = 32'h44;
    mem[1022] = 32'hFFFF_FFFF; mem[1023] = 32'h1; mem[0] = 32'h5;
    mem[10] = 32'h100; mem[11] = 32'h200;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_checksum", checksum, 0);
    reset = 0;

    // Basic 4-word dump, ready held high.
    reset_stats(); out_ready = 1;
    start_dump(4, 4);
    run_until_done(0, 0, 100);
    chk("t1_checksum", checksum, 32'hAA);
    chk("t1_busy_cycles", n_busy, 12);
    chk("t1_words", n_hs, 4);
    chk("t1_done_count", n_done, 1);
    chk("t1_first_valid_lat", first_v_cyc - acc_cyc, 3);
    if (n_hs == 4) begin
      chk("t1_addr0", hs_addr[0], 4);
      chk("t1_addr3", hs_addr[3], 7);
      chk("t1_data3", hs_data[3], 32'h44);
    end

    // Same dump with ready toggling every cycle.
    reset_stats(); out_ready = 0;
    start_dump(4, 4);
    run_until_done(1, 0, 200);
    chk("t2_words", n_hs, 4);
    chk("t2_checksum", checksum, 32'hAA);
    if (n_hs == 4)
      for (int i = 0; i < 4; i++) chk("t2_data", hs_data[i], 32'h11 * (i + 1));

    // Range crossing the top of memory.
    reset_stats(); out_ready = 1;
    start_dump(1022, 3);
    run_until_done(0, 0, 100);
    chk("t3_checksum", checksum, 32'h5);
    chk("t3_words", n_hs, 3);
    if (n_hs == 3) begin
      chk("t3_addr0", hs_addr[0], 1022);
      chk("t3_addr1", hs_addr[1], 1023);
      chk("t3_addr2", hs_addr[2], 0);
    end

    // Empty dump.
    reset_stats();
    start_dump(100, 0);
    run_until_done(0, 0, 20);
    chk("t4_done_count", n_done, 1);
    chk("t4_busy_cycles", n_busy, 0);
    chk("t4_words", n_hs, 0);
    chk("t4_checksum", checksum, 0);

    // start pulsed again while a word is being offered.
    reset_stats(); out_ready = 1;
    start_dump(4, 4);
    run_until_done(0, 1, 100);
    chk("t5_words", n_hs, 4);
    chk("t5_done_count", n_done, 1);
    chk("t5_checksum", checksum, 32'hAA);

    // Reset during the second word's CAP cycle.
    reset_stats(); out_ready = 1;
    start_dump(4, 4);
    nreq = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rd_en) nreq++;
      if (nreq == 2) break;
      @(posedge clk); #1;
    end
    chk("t6_reached_req2", nreq, 2);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_last", out_last, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_addr", out_addr, 0);
    chk("t6_mem_rd_en", mem_rd_en, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cpu_hold", cpu_hold, 0);
    chk("t6_done", done, 0);
    chk("t6_checksum", checksum, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done", n_done, 0);
    reset_stats();
    start_dump(10, 2);
    run_until_done(0, 0, 100);
    chk("t6_words", n_hs, 2);
    chk("t6_fresh_checksum", checksum, 32'h300);
    if (n_hs == 2) chk("t6_addr1", hs_addr[1], 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
